// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

    localparam int SA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_adder_if import serial_adder_pkg::*; #(
    parameter int W = SA_W_DEFAULT
);
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ci_in;
    logic         ready;
    logic [W-1:0] sum_out;
    logic         co_out;
    logic         valid;

    modport master (
        output start, a_in, b_in, ci_in,
        input  ready, sum_out, co_out, valid
    );

    modport slave (
        input  start, a_in, b_in, ci_in,
        output ready, sum_out, co_out, valid
    );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - W-bit adder that time-shares one full_adder cell, LSB first
module serial_adder import serial_adder_pkg::*; #(
    parameter int W = SA_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rstn,
    serial_adder_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    sa_state_e     state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          valid_q;
    logic          fa_sum;
    logic          fa_co;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .ci  (carry),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.a_in;
                        b_sh    <= bus.b_in;
                        carry   <= bus.ci_in;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the LSB lands in bit 0 after W shifts.
                    sum_sh <= (sum_sh >> 1) | (W'(fa_sum) << (W - 1));
                    carry  <= fa_co;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.valid   = valid_q;
    assign bus.sum_out = sum_sh;
    assign bus.co_out  = carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at W=8 and W=1
module tb_serial_adder;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    serial_adder_if #(.W(8)) bus8 ();
    serial_adder_if #(.W(1)) bus1 ();

    serial_adder #(.W(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));
    serial_adder #(.W(1)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {co,sum} is the plain integer sum reduced modulo 2^(w+1).
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic ci);
        logic [32:0] full;
        logic [32:0] mask;
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        mask = (33'd1 << (w + 1)) - 33'd1;
        return full & mask;
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input int poke, input string tag);
        int n;
        int extra;
        logic [32:0] exp;
        exp = ref_add(8, {24'd0, a}, {24'd0, b}, ci);
        n = 0;
        while (!bus8.ready && n < 40) begin step(); n++; end
        check({tag, " ready_idle"}, {32'd0, bus8.ready}, 33'd1);
        bus8.a_in = a; bus8.b_in = b; bus8.ci_in = ci; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.ci_in = 1'($urandom);
        check({tag, " ready_low"}, {32'd0, bus8.ready}, 33'd0);
        n = 0;
        while (!bus8.valid && n < 40) begin
            if (n == poke) begin
                bus8.start = 1'b1; bus8.a_in = 8'h11; bus8.b_in = 8'h22;
            end
            step();
            bus8.start = 1'b0;
            n++;
        end
        check({tag, " latency"}, 33'(n), 33'd8);
        check({tag, " result"}, {24'd0, bus8.co_out, bus8.sum_out}, exp);
        step();
        check({tag, " ready_back"}, {32'd0, bus8.ready}, 33'd1);
        check({tag, " valid_drop"}, {32'd0, bus8.valid}, 33'd0);
        check({tag, " result_hold"}, {24'd0, bus8.co_out, bus8.sum_out}, exp);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus8.valid) extra++;
        end
        check({tag, " no_extra_valid"}, 33'(extra), 33'd0);
    endtask

    task automatic op1(input logic a, input logic b, input logic ci, input string tag);
        int n;
        logic [32:0] exp;
        exp = ref_add(1, {31'd0, a}, {31'd0, b}, ci);
        n = 0;
        while (!bus1.ready && n < 20) begin step(); n++; end
        bus1.a_in = a; bus1.b_in = b; bus1.ci_in = ci; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        bus1.a_in = ~a; bus1.b_in = ~b; bus1.ci_in = ~ci;
        check({tag, " ready_low"}, {32'd0, bus1.ready}, 33'd0);
        n = 0;
        while (!bus1.valid && n < 20) begin step(); n++; end
        check({tag, " latency"}, 33'(n), 33'd1);
        check({tag, " result"}, {31'd0, bus1.co_out, bus1.sum_out}, exp);
        step();
        check({tag, " ready_back"}, {32'd0, bus1.ready}, 33'd1);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.ci_in = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.ci_in = 1'b0;
        step();
        step();
        check("reset ready", {32'd0, bus8.ready}, 33'd1);
        check("reset valid", {32'd0, bus8.valid}, 33'd0);
        check("reset result", {24'd0, bus8.co_out, bus8.sum_out}, 33'd0);
        check("reset1 result", {31'd0, bus1.co_out, bus1.sum_out}, 33'd0);
        rstn = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, -1, "5a_3c");
        op8(8'hFF, 8'h01, 1'b0, -1, "ff_01");
        op8(8'hFF, 8'hFF, 1'b1, -1, "ff_ff_c");
        op8(8'h5A, 8'h3C, 1'b0, 3, "start_in_run");
        for (int i = 0; i < 8; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), -1, "random");

        // Start held high: one result every W+2 cycles.
        bus8.a_in = 8'h01; bus8.b_in = 8'h01; bus8.ci_in = 1'b0; bus8.start = 1'b1;
        n = 0;
        while (!bus8.valid && n < 40) begin step(); n++; end
        check("b2b first", {24'd0, bus8.co_out, bus8.sum_out}, ref_add(8, 32'd1, 32'd1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin step(); n++; end while (!bus8.valid && n < 40);
            check("b2b period", 33'(n), 33'd10);
            check("b2b sum", {24'd0, bus8.co_out, bus8.sum_out}, ref_add(8, 32'd1, 32'd1, 1'b0));
        end
        bus8.start = 1'b0;
        n = 0;
        while (!bus8.ready && n < 40) begin step(); n++; end

        // Abort three cycles into RUN.
        bus8.a_in = 8'h5A; bus8.b_in = 8'h3C; bus8.ci_in = 1'b0; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step(); step(); step();
        #2 rstn = 1'b0;
        #1;
        check("abort ready", {32'd0, bus8.ready}, 33'd1);
        check("abort valid", {32'd0, bus8.valid}, 33'd0);
        check("abort sum", {25'd0, bus8.sum_out}, 33'd0);
        check("abort co", {32'd0, bus8.co_out}, 33'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        op8(8'h0F, 8'h01, 1'b0, -1, "after_abort");

        op1(1'b1, 1'b1, 1'b1, "w1_111");
        for (int i = 0; i < 8; i++)
            op1(1'(i), 1'(i >> 1), 1'(i >> 2), "w1_combo");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
